rf_cmd_engine: RTL

//  Command-driven initiator for the 8-entry reg_file. Accepts valid/ready commands
//  (WRITE, READ, ADD, SWAP), sequences the reg_file write and dual-read ports, and

---
 rtl/rf_pkg.sv | 21 ++
 rtl/reg_file.sv | 28 ++
 rtl/rf_cmd_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared encodings and default widths for the register-file command engine.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_ADD   = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB2  = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/reg_file.sv
// 2**ADDR_W-entry register file: combinational dual read, synchronous write.
module reg_file #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];

endmodule

// File: rtl/rf_cmd_engine.sv
// Command-driven initiator for reg_file: executes WRITE/READ/ADD/SWAP and
// returns one valid/ready response per accepted command.
module rf_cmd_engine
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2
);

  state_e            state;
  state_e            next_state;
  op_e               op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] src1_q;
  logic [ADDR_W-1:0] src2_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] tmp_q;
  logic [DATA_W-1:0] tmp_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_carry_d;
  logic [DATA_W:0]   add_sum;
  logic              accept;

  assign accept      = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign add_sum     = {1'b0, rf_rd_data1} + {1'b0, rf_rd_data2};
  assign rf_rd_addr1 = src1_q;
  assign rf_rd_addr2 = src2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state, reg_file write port and response datapath.
  always_comb begin
    next_state  = state;
    rf_we       = 1'b0;
    rf_wr_addr  = dst_q;
    rf_wr_data  = imm_q;
    rsp_data_d  = rsp_data;
    rsp_carry_d = rsp_carry;
    tmp_d       = tmp_q;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_EXEC;
      end
      ST_EXEC: begin
        next_state  = ST_RESP;
        rsp_carry_d = 1'b0;
        case (op_q)
          OP_WRITE: begin
            rf_we      = 1'b1;
            rsp_data_d = imm_q;
          end
          OP_READ: begin
            rsp_data_d = rf_rd_data1;
          end
          OP_ADD: begin
            rf_we       = 1'b1;
            rf_wr_data  = add_sum[DATA_W-1:0];
            rsp_data_d  = add_sum[DATA_W-1:0];
            rsp_carry_d = add_sum[DATA_W];
          end
          OP_SWAP: begin
            // First half of the swap; old src1 parks in tmp for WB2.
            rf_we      = 1'b1;
            rf_wr_addr = src1_q;
            rf_wr_data = rf_rd_data2;
            tmp_d      = rf_rd_data1;
            next_state = ST_WB2;
          end
        endcase
      end
      ST_WB2: begin
        rf_we       = 1'b1;
        rf_wr_addr  = src2_q;
        rf_wr_data  = tmp_q;
        rsp_data_d  = tmp_q;
        rsp_carry_d = 1'b0;
        next_state  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      tmp_q     <= '0;
      op_q      <= OP_WRITE;
      dst_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
    end else begin
      cmd_ready <= (next_state == ST_IDLE);
      rsp_valid <= (next_state == ST_RESP);
      rsp_data  <= rsp_data_d;
      rsp_carry <= rsp_carry_d;
      tmp_q     <= tmp_d;
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        dst_q  <= cmd_dst;
        src1_q <= cmd_src1;
        src2_q <= cmd_src2;
        imm_q  <= cmd_imm;
      end
    end
  end

endmodule
